uart_tx_result: RTL and testbench
=================================

# uart_tx_result

Serializes processor result bytes onto the UART transmit line, 8N1 by default, LSB first. Sits downstream of `Processor_Top` in the `UART` top level and is the return path mirroring `UART_RX`. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It drives `serial_tx` with back-to-back frames until the FIFO is empty.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, truncated; 434 at the defaults.
- `FIFO_DEPTH`, default 16: power of two, ≥2.
- `clk` in 1: single system clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `data_in` in 8: byte to send (`int8_t`).
- `data_valid` in 1: `data_in` is valid this cycle.
- `data_ready` out 1: FIFO not full. A byte is accepted on an edge where `data_valid && data_ready`.
- `serial_tx` out 1: UART line, idle high, registered.
- `tx_busy` out 1: high when the state is not IDLE or the FIFO is non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of bytes currently buffered.

## Operation
- Reset values: `serial_tx`=1, `data_ready`=1, `tx_busy`=0, `fifo_count`=0, state IDLE, FIFO empty.
- States and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the bit counter and baud counter, go to START.
  - START: `serial_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send bits 0..7, `CLKS_PER_BIT` cycles each. After bit 7, go to PARITY if `UART_TX_PARITY_EN` is defined, else go to STOP.
  - PARITY: `serial_tx` = XOR of the 8 data bits (even parity), for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `serial_tx`=1 for `CLKS_PER_BIT` cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: counts `0..CLKS_PER_BIT-1`, with width `$clog2(CLKS_PER_BIT)`. Wraps to 0 on every bit boundary.
- FIFO:
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth.
  - Full when `fifo_count==FIFO_DEPTH`; empty when `fifo_count==0`.
  - Push and pop on the same edge leave `fifo_count` unchanged.
  - Pop is only issued when the FIFO is non-empty. Push is only accepted when not full.
  - A push into an empty FIFO is not visible to the state machine until the next edge.
- `data_in` is ignored whenever `data_valid`=0 or `data_ready`=0. No overflow is possible.
- Reset asserted mid-frame:
  - `serial_tx` returns to 1 immediately (asynchronously).
  - The FIFO is emptied, and the in-flight byte and all buffered bytes are discarded.
  - Operation resumes from IDLE after reset is released.

## Timing
- Accepting edge k (FIFO empty, state IDLE):
  - Edge k+1 pops the byte.
  - `serial_tx` goes low after edge k+1.
- Frame length:
  - 10·`CLKS_PER_BIT` cycles, or 11· with parity.
  - Back-to-back frames repeat at exactly that period.
- `data_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after the next pop.
- `tx_busy` falls the cycle after the last stop-bit cycle completes with the FIFO empty.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
  - Defined: an even-parity bit is inserted between bit 7 and the stop bit; the frame is 11 bit-times.
  - Undefined: the PARITY state and its logic are not compiled; 8N1, 10 bit-times.

## Structure
- `UART_pkg` holds:
  - the `int8_t` and `One_t` typedefs;
  - the `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - the default `CLK_FREQ` and `BAUD` constants.
- Sub-module `tx_fifo`: synchronous FIFO with push, pop, full, empty and count. It is instantiated once.
- Baud counter, shift register and FSM are in the top of the block.

## Test plan
- Reset, then push 0x55 once:
  - `serial_tx` low after edge k+1;
  - line sequence 0,1,0,1,0,1,0,1,0,1, each held 434 cycles;
  - then idle high and `tx_busy`=0.
- Push 0x00, 0xFF, 0xA5 on consecutive cycles: three frames totalling 13020 cycles with no high gap between stop and start; bytes decoded correctly by the bench.
- Hold `data_valid`=1 with `serial_tx` stalled in the first frame:
  - 17 bytes accepted in total (16 buffered plus 1 popped);
  - `data_ready`=0 once `fifo_count`=16;
  - the 18th byte is not accepted until the next pop.
- Assert `reset` in DATA bit 3 of 0x3C with 5 bytes queued:
  - `serial_tx`=1 immediately and `fifo_count`=0;
  - after release the line stays idle with no residual frame.
- With `UART_TX_PARITY_EN`, send 0x07: parity bit 1, frame 4774 cycles. Send 0x03: parity bit 0.
- With `CLK_FREQ`=1_000_000 and `BAUD`=100_000, send 0xC3: each bit is held exactly 10 cycles.

Source files
------------

// File: rtl/uart_tx_result_pkg.sv
// Shared types and default line settings for the result transmit path.
// Parity insertion is enabled by defining UART_TX_PARITY_EN.
package UART_pkg;

    typedef logic [7:0] int8_t;
    typedef logic       One_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;

    // Counter width that stays legal when a bit lasts a single cycle.
    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_result_tx_fifo.sv
// Small synchronous byte FIFO buffering result bytes ahead of the serializer.
// Pointers wrap modulo DEPTH; a separate count distinguishes full from empty.
module tx_fifo
    import UART_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  int8_t                    din,
    input  logic                     pop,
    output int8_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    int8_t          mem [DEPTH];
    logic  [AW-1:0] wr_ptr;
    logic  [AW-1:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: discarding is done by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_result.sv
// Result-byte UART transmitter: FIFO-buffered, 8N1 LSB first, back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_result
    import UART_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  int8_t                         data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          serial_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    tx_state_e     state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    int8_t         shift;
    logic          bit_end;
    logic          pop;
    logic          tx_next;
    int8_t         head;
    logic          full;
    logic          empty;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_valid),
        .din   (data_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign data_ready = !full;
    assign tx_busy    = (state != IDLE) || !empty;
    assign bit_end    = (baud_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = empty ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is registered, so its next value follows the next state.
    always_comb begin
        pop     = 1'b0;
        tx_next = 1'b1;
        if (state_next == START && (state == IDLE || state == STOP)) begin
            pop = 1'b1;
        end
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = (state == DATA && bit_end) ? shift[1] : shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_tx <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            serial_tx <= tx_next;
            if (pop) begin
                shift    <= head;
                baud_cnt <= '0;
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                parity   <= ^head;
`endif
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
                if (state == DATA && bit_end) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_result.sv
// Scoreboard bench for uart_tx_result: a line decoder pops expected bytes,
// directed tasks check bit timing, backpressure and mid-frame reset.
module tb_uart_tx_result;
    import UART_pkg::*;

    localparam int CPB  = 50_000_000 / 115_200;
    localparam int CPB2 = 1_000_000 / 100_000;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       serial_tx;
    logic       tx_busy;
    logic [4:0] fifo_count;

    logic [7:0] d2;
    logic       v2;
    logic       rdy2;
    logic       tx2;
    logic       busy2;
    logic [4:0] cnt2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_result dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .serial_tx  (serial_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_result #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (d2),
        .data_valid (v2),
        .data_ready (rdy2),
        .serial_tx  (tx2),
        .tx_busy    (busy2),
        .fifo_count (cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic line(input int inst);
        return (inst == 0) ? serial_tx : tx2;
    endfunction

    function automatic logic busy(input int inst);
        return (inst == 0) ? tx_busy : busy2;
    endfunction

    // Line decoder: samples mid-bit and scores each finished frame.
    logic       rx_busy = 1'b0;
    logic       rx_ok;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    int         rx_cnt;
    int         rx_bi;

    always @(negedge clk) begin
        if (reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (!serial_tx) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_ok   = 1'b1;
                start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
        end
        if (!reset && rx_busy && (rx_cnt % CPB) == CPB / 2) begin
            rx_bi = rx_cnt / CPB;
            if (rx_bi >= 1 && rx_bi <= 8) rx_byte[rx_bi-1] = serial_tx;
            else if (serial_tx !== frame_bit(rx_byte, rx_bi)) rx_ok = 1'b0;
            if (rx_bi == NB - 1) begin
                rx_busy = 1'b0;
                check("frame_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    rx_exp = exp_q.pop_front();
                    check("rx_byte", 32'(rx_byte), 32'(rx_exp));
                    check("rx_framing", 32'(rx_ok), 1);
                end
            end
        end
    end

    task automatic send(input int inst, input logic [7:0] b);
        @(negedge clk);
        if (inst == 0) begin
            check("ready_before_push", 32'(data_ready), 1);
            data_valid = 1'b1;
            data_in    = b;
            exp_q.push_back(b);
        end else begin
            v2 = 1'b1;
            d2 = b;
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        v2         = 1'b0;
    endtask

    // Entered just after the accepting edge k.
    task automatic check_frame(input int inst, input logic [7:0] b,
                               input int cpb);
        logic ok;
        check("line_high_at_k", 32'(line(inst)), 1);
        @(posedge clk);
        #1;
        check("line_low_after_k1", 32'(line(inst)), 0);
        for (int i = 0; i < NB; i++) begin
            ok = 1'b1;
            repeat (cpb) begin
                @(negedge clk);
                if (line(inst) !== frame_bit(b, i)) ok = 1'b0;
            end
            check($sformatf("bit%0d_hold_%0h", i, b), 32'(ok), 1);
        end
        @(negedge clk);
        check("line_idle_after", 32'(line(inst)), 1);
        check("busy_low_after", 32'(busy(inst)), 0);
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        while (tx_busy && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(tx_busy), 0);
        t = cyc;
    endtask

    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int  t_end;
        int  acc;
        int  cyc0;
        int  n;
        logic ok;

        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        v2         = 1'b0;
        d2         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial_tx", 32'(serial_tx), 1);
        check("rst_data_ready", 32'(data_ready), 1);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_tx2", 32'(tx2), 1);
        @(negedge clk);
        reset = 1'b0;

        // Single 0x55 frame with exact bit timing.
        send(0, 8'h55);
        check("count_after_push", 32'(fifo_count), 1);
        check("busy_after_push", 32'(tx_busy), 1);
        check_frame(0, 8'h55, CPB);
        check("queue_drained_55", 32'(exp_q.size()), 0);

        // Three bytes on consecutive cycles, no gap between frames.
        start_q.delete();
        @(negedge clk);
        data_valid = 1'b1;
        data_in = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk);
        data_in = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk);
        data_in = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle(t_end);
        check("three_starts", 32'(start_q.size()), 3);
        if (start_q.size() == 3) begin
            check("gap_1_2", 32'(start_q[1] - start_q[0]), FRAME);
            check("gap_2_3", 32'(start_q[2] - start_q[1]), FRAME);
            check("three_total", 32'(t_end - start_q[0]), 3 * FRAME);
        end
        check("queue_drained_3", 32'(exp_q.size()), 0);

        // Hold valid high while the first frame is on the line.
        acc = 0;
        @(negedge clk);
        data_valid = 1'b1;
        cyc0 = cyc;
        for (int i = 0; i < 40; i++) begin
            data_in = 8'h10 + 8'(acc);
            if (data_ready) begin
                exp_q.push_back(data_in);
                acc++;
            end
            @(negedge clk);
        end
        check("fill_accepted", 32'(acc), 17);
        check("fill_count", 32'(fifo_count), 16);
        check("fill_ready_low", 32'(data_ready), 0);
        n = 0;
        while (!data_ready && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("ready_rise_cycle", 32'(cyc - cyc0), FRAME + 2);
        exp_q.push_back(data_in);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check("fill_count_after_18", 32'(fifo_count), 16);
        check("second_frame_start", 32'(serial_tx), 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_line", 32'(serial_tx), 1);
        check("async_rst_count", 32'(fifo_count), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset in data bit 3 of 0x3C with five bytes queued.
        @(negedge clk);
        data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = (i == 0) ? 8'h3C : 8'h60 + 8'(i);
            exp_q.push_back(data_in);
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("queued_five", 32'(fifo_count), 5);
        repeat (1945) @(negedge clk);
        check("in_bit3", 32'(serial_tx), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_line", 32'(serial_tx), 1);
        check("rst_mid_count", 32'(fifo_count), 0);
        check("rst_mid_busy", 32'(tx_busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (serial_tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check("no_residual_frame", 32'(ok), 1);

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07);
        check_frame(0, 8'h07, CPB);
        send(0, 8'h03);
        check_frame(0, 8'h03, CPB);
        check("parity_queue_drained", 32'(exp_q.size()), 0);
`endif

        // Short bit period on the second instance.
        send(1, 8'hC3);
        check("cnt2_after_push", 32'(cnt2), 1);
        check_frame(1, 8'hC3, CPB2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
